// File: rtl/skolem_ashr1_sweep_checker_if.sv
// Handshake and result bus between the sweep checker and whoever drives start,
// plus the vector/answer pair exchanged with the Skolem block under test.
interface skolem_ashr1_sweep_checker_if #(
  parameter int W = 4
);
  logic             start;
  logic [2*W-1:0]   sk_in;
  logic [W-1:0]     sk_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [2*W:0]     inv_count;
  logic [2*W:0]     fail_count;
  logic             first_fail_valid;
  logic [2*W-1:0]   first_fail_vec;
  logic [W-1:0]     first_fail_x;

  // Environment side: issues start and feeds back the Skolem answer.
  modport master (
    output start, sk_out,
    input  sk_in, busy, done, pass, inv_count, fail_count,
           first_fail_valid, first_fail_vec, first_fail_x
  );

  // Checker side.
  modport slave (
    input  start, sk_out,
    output sk_in, busy, done, pass, inv_count, fail_count,
           first_fail_valid, first_fail_vec, first_fail_x
  );
endinterface

// File: rtl/skolem_ashr1_sweep_checker.sv
// Exhaustive sweep checker for a bvule/bvashr1 Skolem block: drives every
// (s,t) vector, samples the returned x and verifies s >>a x <=u t wherever
// the invertibility condition holds.
module skolem_ashr1_sweep_checker #(
  parameter int W       = 4,
  parameter int SETTLE  = 0,
  parameter int SWAP_ST = 0
) (
  input logic clk,
  input logic rst,
  skolem_ashr1_sweep_checker_if.slave bus
);
  localparam int VW = 2 * W;
  localparam int CW = 2 * W + 1;

  typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, FLUSH, DONE} state_t;

  state_t         state;
  logic [3:0]     hold;
  logic [VW-1:0]  vec;
  logic [VW-1:0]  pipe_v;
  logic [W-1:0]   pipe_x;
  logic           pipe_valid;
  logic           busy;
  logic           done;
  logic           pass;
  logic [CW-1:0]  inv_count;
  logic [CW-1:0]  fail_count;
  logic           ff_valid;
  logic [VW-1:0]  ff_vec;
  logic [W-1:0]   ff_x;

  logic [W-1:0]   s;
  logic [W-1:0]   t;
  logic [W-1:0]   sh;
  logic [W-1:0]   r;
  logic           ic;
  logic           ok;
  logic           bad;

  // Check stage: decode the registered vector, evaluate IC and the goal.
  always_comb begin
    s = '0;
    t = '0;
    if (SWAP_ST != 0) begin
      s = pipe_v[VW-1:W];
      t = pipe_v[W-1:0];
    end else begin
      s = pipe_v[W-1:0];
      t = pipe_v[VW-1:W];
    end
    // Shifting by W-1 already yields all sign bits, so larger amounts saturate.
    sh  = ({1'b0, pipe_x} >= (W+1)'(W)) ? W'(W - 1) : pipe_x;
    r   = W'($signed(s) >>> sh);
    ic  = !s[W-1] || (s <= t);
    ok  = (r <= t);
    bad = ic && !ok;
  end

  // Sweep FSM, sample pipeline and result accumulation in one registered block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold       <= '0;
      vec        <= '0;
      pipe_v     <= '0;
      pipe_x     <= '0;
      pipe_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      inv_count  <= '0;
      fail_count <= '0;
      ff_valid   <= 1'b0;
      ff_vec     <= '0;
      ff_x       <= '0;
    end else begin
      pipe_valid <= 1'b0;
      if (pipe_valid) begin
        if (ic) inv_count <= inv_count + CW'(1);
        if (bad) fail_count <= fail_count + CW'(1);
        if (bad && !ff_valid) begin
          ff_valid <= 1'b1;
          ff_vec   <= pipe_v;
          ff_x     <= pipe_x;
        end
      end
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            vec        <= '0;
            hold       <= '0;
            inv_count  <= '0;
            fail_count <= '0;
            ff_valid   <= 1'b0;
            ff_vec     <= '0;
            ff_x       <= '0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            state      <= (SETTLE == 0) ? SAMPLE : DRIVE;
          end else if (state == DONE && !done) begin
            done <= 1'b1;
            busy <= 1'b0;
            pass <= (fail_count == '0);
          end
        end
        DRIVE: begin
          hold <= hold + 4'd1;
          if (hold == 4'(SETTLE - 1)) state <= SAMPLE;
        end
        SAMPLE: begin
          pipe_v     <= vec;
          pipe_x     <= bus.sk_out;
          pipe_valid <= 1'b1;
          hold       <= '0;
          if (vec == '1) begin
            state <= FLUSH;
          end else begin
            vec   <= vec + VW'(1);
            state <= (SETTLE == 0) ? SAMPLE : DRIVE;
          end
        end
        FLUSH: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sk_in            = vec;
  assign bus.busy             = busy;
  assign bus.done             = done;
  assign bus.pass             = pass;
  assign bus.inv_count        = inv_count;
  assign bus.fail_count       = fail_count;
  assign bus.first_fail_valid = ff_valid;
  assign bus.first_fail_vec   = ff_vec;
  assign bus.first_fail_x     = ff_x;
endmodule

// File: tb/tb_skolem_ashr1_sweep_checker.sv
// Directed bench for the sweep checker: golden and broken Skolem answers,
// a slow-settle instance, mid-sweep reset and start handling.
module tb_skolem_ashr1_sweep_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0;
  logic start2 = 1'b0;
  int   mode = 0;
  int   errors = 0;
  int   checks = 0;
  int   cycles;

  skolem_ashr1_sweep_checker_if #(.W(4)) bus1 ();
  skolem_ashr1_sweep_checker_if #(.W(4)) bus2 ();

  skolem_ashr1_sweep_checker #(.W(4), .SETTLE(0), .SWAP_ST(0)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  skolem_ashr1_sweep_checker #(.W(4), .SETTLE(3), .SWAP_ST(0)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Golden answer: non-negative s shifts to 0, negative s is smallest unshifted.
  function automatic logic [3:0] golden(input logic [7:0] v);
    return v[3] ? 4'h0 : 4'hF;
  endfunction

  assign bus1.start  = start1;
  assign bus2.start  = start2;
  assign bus1.sk_out = (mode == 0) ? golden(bus1.sk_in) : (mode == 1) ? 4'h0 : 4'hF;
  assign bus2.sk_out = golden(bus2.sk_in);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one clock on the selected checker; returns just after acceptance.
  task automatic applyStimulus(input int which);
    @(negedge clk);
    if (which == 1) start1 = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Count rising edges until done is seen; -1 if the bound expires.
  task automatic waitDone(input int which, output int n);
    n = -1;
    for (int i = 1; i <= 3000; i++) begin
      @(posedge clk);
      #1;
      if ((which == 1 && bus1.done) || (which == 2 && bus2.done)) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_sk_in", 32'(bus1.sk_in), 32'h0);
    checkOutput("rst_busy", 32'(bus1.busy), 32'h0);
    checkOutput("rst_done", 32'(bus1.done), 32'h0);
    checkOutput("rst_pass", 32'(bus1.pass), 32'h0);
    checkOutput("rst_inv", 32'(bus1.inv_count), 32'h0);
    checkOutput("rst_ffv", 32'(bus1.first_fail_valid), 32'h0);
    rst = 1'b0;

    // Golden sweep.
    mode = 0;
    applyStimulus(1);
    checkOutput("t1_busy", 32'(bus1.busy), 32'h1);
    checkOutput("t1_sk_in0", 32'(bus1.sk_in), 32'h0);
    waitDone(1, cycles);
    checkOutput("t1_cycles", 32'(cycles), 32'd258);
    checkOutput("t1_inv", 32'(bus1.inv_count), 32'd164);
    checkOutput("t1_fail", 32'(bus1.fail_count), 32'd0);
    checkOutput("t1_pass", 32'(bus1.pass), 32'h1);
    checkOutput("t1_busy_lo", 32'(bus1.busy), 32'h0);
    checkOutput("t1_ffv", 32'(bus1.first_fail_valid), 32'h0);

    // Answer stuck at zero.
    mode = 1;
    applyStimulus(1);
    waitDone(1, cycles);
    checkOutput("t2_fail", 32'(bus1.fail_count), 32'd28);
    checkOutput("t2_inv", 32'(bus1.inv_count), 32'd164);
    checkOutput("t2_vec", 32'(bus1.first_fail_vec), 32'h01);
    checkOutput("t2_x", 32'(bus1.first_fail_x), 32'h0);
    checkOutput("t2_ffv", 32'(bus1.first_fail_valid), 32'h1);
    checkOutput("t2_pass", 32'(bus1.pass), 32'h0);

    // Answer stuck at all ones.
    mode = 2;
    applyStimulus(1);
    waitDone(1, cycles);
    checkOutput("t3_fail", 32'(bus1.fail_count), 32'd28);
    checkOutput("t3_inv", 32'(bus1.inv_count), 32'd164);
    checkOutput("t3_vec", 32'(bus1.first_fail_vec), 32'h88);
    checkOutput("t3_x", 32'(bus1.first_fail_x), 32'hF);
    checkOutput("t3_pass", 32'(bus1.pass), 32'h0);

    // Slow-settle instance holds each vector four cycles.
    applyStimulus(2);
    checkOutput("t4_hold0", 32'(bus2.sk_in), 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("t4_hold3", 32'(bus2.sk_in), 32'h0);
    @(negedge clk);
    checkOutput("t4_next", 32'(bus2.sk_in), 32'h1);
    waitDone(2, cycles);
    checkOutput("t4_cycles", 32'(cycles + 4), 32'd1026);
    checkOutput("t4_inv", 32'(bus2.inv_count), 32'd164);
    checkOutput("t4_pass", 32'(bus2.pass), 32'h1);

    // Start while busy is ignored.
    mode = 0;
    applyStimulus(1);
    repeat (20) @(negedge clk);
    checkOutput("t6_mid_vec", 32'(bus1.sk_in), 32'h14);
    applyStimulus(1);
    checkOutput("t6_ignored_vec", 32'(bus1.sk_in), 32'h16);
    checkOutput("t6_ignored_busy", 32'(bus1.busy), 32'h1);
    waitDone(1, cycles);
    checkOutput("t6_cycles", 32'(cycles + 22), 32'd258);
    checkOutput("t6_inv", 32'(bus1.inv_count), 32'd164);
    checkOutput("t6_pass", 32'(bus1.pass), 32'h1);

    // Start from DONE clears results and begins a new sweep.
    applyStimulus(1);
    checkOutput("t6_restart_done", 32'(bus1.done), 32'h0);
    checkOutput("t6_restart_busy", 32'(bus1.busy), 32'h1);
    checkOutput("t6_restart_inv", 32'(bus1.inv_count), 32'h0);
    checkOutput("t6_restart_pass", 32'(bus1.pass), 32'h0);
    checkOutput("t6_restart_vec", 32'(bus1.sk_in), 32'h0);

    // Reset in the middle of that sweep.
    repeat (64) @(negedge clk);
    checkOutput("t5_at_40", 32'(bus1.sk_in), 32'h40);
    checkOutput("t5_partial_inv", 32'(bus1.inv_count), 32'd32);
    #2 rst = 1'b1;
    #1;
    checkOutput("t5_rst_vec", 32'(bus1.sk_in), 32'h0);
    checkOutput("t5_rst_busy", 32'(bus1.busy), 32'h0);
    checkOutput("t5_rst_inv", 32'(bus1.inv_count), 32'h0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t5_idle_vec", 32'(bus1.sk_in), 32'h0);
    rst = 1'b0;
    applyStimulus(1);
    waitDone(1, cycles);
    checkOutput("t5_cycles", 32'(cycles), 32'd258);
    checkOutput("t5_inv", 32'(bus1.inv_count), 32'd164);
    checkOutput("t5_fail", 32'(bus1.fail_count), 32'd0);
    checkOutput("t5_pass", 32'(bus1.pass), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
